tdc_interval_meter: RTL and testbench

Receive-side companion to the TDC test-pulse generator. It samples a start/stop pulse pair, measures the start-to-stop interval in `clk` cycles, and classifies the interval as pass or fail against an expected value and tolerance. Results go out through a valid/ready handshake, and running pass/fail tallies are kept. It sits on the bench board loop-back path, so the tester's start/stop outputs can be self-checked before they reach a chrono chip.

---
 rtl/tdc_meter_pkg.sv | 15 +
 rtl/tdc_interval_meter_sync_edge.sv | 32 +++
 rtl/tdc_interval_meter.sv | 149 ++++++++++++++
 tb/tb_tdc_interval_meter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_meter_pkg.sv
// Shared types and default constants for the TDC interval meter.
package tdc_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } meter_state_e;

  localparam int DEF_CNT_W   = 28;
  localparam int DEF_TIMEOUT = 12582912;
  localparam int DEF_TOL     = 2;
  localparam int TALLY_W     = 16;

endpackage

// File: rtl/tdc_interval_meter_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Pulse appears 3 cycles after the input rises, the same for every instance.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  // NOTE: the whole chain resets to 1, so a line already high when reset drops
  // looks like "no change" rather than a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      rise   <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise   <= sync_q & ~prev_q;
    end
  end

endmodule

// File: rtl/tdc_interval_meter.sv
// Start/stop interval meter: counts clk cycles between synchronized start and
// stop edges, grades the result against expected +/- TOL, keeps pass/fail tallies.
module tdc_interval_meter
  import tdc_meter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TOL     = DEF_TOL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic               stop_in,
  input  logic [CNT_W-1:0]   expected,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_data,
  output logic               res_timeout,
  output logic               res_pass,
  output logic [TALLY_W-1:0] pass_cnt,
  output logic [TALLY_W-1:0] fail_cnt,
  output logic               busy
);

  meter_state_e state_q, state_d;

  logic             start_rise, stop_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] data_d;
  logic             timeout_d, pass_d, enter_done;
  logic [CNT_W:0]   diff;
  logic [TALLY_W-1:0] pass_q, fail_q;

  sync_edge u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (start_in),
    .rise (start_rise)
  );

  sync_edge u_stop_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (stop_in),
    .rise (stop_rise)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // NOTE: every signal written here gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    data_d     = res_data;
    timeout_d  = res_timeout;
    pass_d     = res_pass;
    enter_done = 1'b0;
    diff       = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          exp_d = expected;
          if (stop_rise) begin
            data_d     = '0;
            timeout_d  = 1'b0;
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        // Later start edges are ignored: the first start owns the measurement.
        if (stop_rise) begin
          data_d     = cnt_inc;
          timeout_d  = 1'b0;
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          data_d     = CNT_W'(TIMEOUT);
          timeout_d  = 1'b1;
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // One extra bit keeps the absolute difference from wrapping.
    if (data_d >= exp_d) diff = {1'b0, data_d} - {1'b0, exp_d};
    else                 diff = {1'b0, exp_d} - {1'b0, data_d};
    if (enter_done) pass_d = !timeout_d && (diff <= (CNT_W+1)'(TOL));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      exp_q       <= '0;
      res_data    <= '0;
      res_timeout <= 1'b0;
      res_pass    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      res_data    <= data_d;
      res_timeout <= timeout_d;
      res_pass    <= pass_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= '0;
      fail_q <= '0;
    end else if (enter_done) begin
      if (pass_d) begin
        if (pass_q != '1) pass_q <= pass_q + TALLY_W'(1);
      end else begin
        if (fail_q != '1) fail_q <= fail_q + TALLY_W'(1);
      end
    end
  end

  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tdc_interval_meter.sv
// Randomized scoreboard bench for tdc_interval_meter: the driver predicts each
// result from pulse spacing, the monitor pops and compares when res_valid rises.
module tb_tdc_interval_meter;

  localparam int CNT_W   = 28;
  localparam int TIMEOUT = 100;
  localparam int TOL     = 2;
  localparam int LAT     = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_in = 1'b0;
  logic             stop_in = 1'b0;
  logic             res_ready = 1'b0;
  logic [CNT_W-1:0] expected = '0;
  logic             res_valid, res_timeout, res_pass, busy;
  logic [CNT_W-1:0] res_data;
  logic [15:0]      pass_cnt, fail_cnt;

  tdc_interval_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_in    (start_in),
    .stop_in     (stop_in),
    .expected    (expected),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_timeout (res_timeout),
    .res_pass    (res_pass),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CNT_W-1:0] data;
    logic             to;
    logic             pass;
    int               pcnt;
    int               fcnt;
    int               rise;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mpass = 0;
  int   mfail = 0;
  int   hold_req = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", (k < 1000), 1);
    repeat (4) @(negedge clk);
  endtask

  // Reference: interval = stop rise - start rise; beyond TIMEOUT it is a timeout.
  task automatic run_txn(input logic [CNT_W-1:0] exp_v, input bit has_stop, input int n);
    exp_t   e;
    int     t0;
    longint d;
    @(negedge clk);
    expected = exp_v;
    start_in = 1'b1;
    stop_in  = has_stop && (n == 0);
    t0 = cyc + 1;
    if (has_stop && n <= TIMEOUT) begin
      e.data = CNT_W'(n);
      e.to   = 1'b0;
    end else begin
      e.data = CNT_W'(TIMEOUT);
      e.to   = 1'b1;
    end
    d = longint'(e.data) - longint'(exp_v);
    if (d < 0) d = -d;
    e.pass = !e.to && (d <= TOL);
    if (e.pass) begin
      if (mpass < 65535) mpass++;
    end else if (mfail < 65535) mfail++;
    e.pcnt = mpass;
    e.fcnt = mfail;
    e.rise = t0 + LAT + int'(e.data);
    exp_q.push_back(e);
    @(negedge clk);
    start_in = 1'b0;
    stop_in  = 1'b0;
    if (has_stop && n > 0) begin
      repeat (n - 1) @(negedge clk);
      stop_in = 1'b1;
      @(negedge clk);
      stop_in = 1'b0;
    end
    wait_idle();
  endtask

  // Monitor: compare on res_valid rise, re-check stability while held.
  initial begin
    exp_t cur;
    bit   seen;
    int   hold_left;
    seen = 0;
    hold_left = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
      end else if (res_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=1 required=0");
          end else begin
            cur = exp_q.pop_front();
            check("valid_cycle", cyc, cur.rise);
            check("res_data", res_data, cur.data);
            check("res_timeout", res_timeout, cur.to);
            check("res_pass", res_pass, cur.pass);
            check("pass_cnt", pass_cnt, cur.pcnt);
            check("fail_cnt", fail_cnt, cur.fcnt);
          end
          seen = 1;
          hold_left = (hold_req > 0) ? hold_req : int'($urandom_range(0, 3));
          hold_req = 0;
        end else begin
          check("hold_data", res_data, cur.data);
          check("hold_timeout", res_timeout, cur.to);
          check("hold_pass", res_pass, cur.pass);
        end
        if (hold_left > 0) begin
          res_ready = 1'b0;
          hold_left--;
        end else begin
          res_ready = 1'b1;
        end
        if (res_ready) seen = 0;
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", res_data, 0);
    check("rst_timeout", res_timeout, 0);
    check("rst_pass", res_pass, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_txn(25, 1, 25);
    hold_req = 10;
    run_txn(25, 1, 60);
    run_txn(7, 0, 0);
    run_txn(1, 1, 0);
    run_txn(3, 1, 0);
    run_txn(2, 1, 0);

    // Lone stop in IDLE must not start anything.
    @(negedge clk);
    stop_in = 1'b1;
    @(negedge clk);
    stop_in = 1'b0;
    repeat (10) @(negedge clk);
    check("lone_stop_busy", busy, 0);
    check("lone_stop_valid", res_valid, 0);

    run_txn(100, 1, TIMEOUT);
    run_txn(100, 1, TIMEOUT + 1);
    run_txn(25, 1, 27);
    run_txn(25, 1, 28);
    run_txn(25, 1, 22);
    run_txn(5, 1, 3);

    for (int i = 0; i < 30; i++) begin
      int e, k, n;
      bit hs;
      e  = int'($urandom_range(0, 110));
      k  = int'($urandom_range(0, 5));
      hs = 1'b1;
      case (k)
        0: n = e + int'($urandom_range(0, 2 * TOL)) - TOL;
        1: n = ($urandom_range(0, 1) == 1) ? e + TOL + 1 : e - TOL - 1;
        2: n = 0;
        3: begin hs = 1'b0; n = 0; end
        4: n = TIMEOUT - 1 + int'($urandom_range(0, 3));
        default: n = int'($urandom_range(1, 110));
      endcase
      if (n < 0) n = 0;
      run_txn(CNT_W'(e), hs, n);
    end

    // Reset mid-COUNT with start held high through reset.
    @(negedge clk);
    expected = 40;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (LAT + 50) @(negedge clk);
    check("busy_mid_count", busy, 1);
    start_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", res_data, 0);
    check("midrst_pass_cnt", pass_cnt, 0);
    check("midrst_fail_cnt", fail_cnt, 0);
    mpass = 0;
    mfail = 0;
    repeat (20) @(negedge clk);
    check("no_spurious_start", busy, 0);
    start_in = 1'b0;
    repeat (5) @(negedge clk);
    run_txn(10, 1, 10);

    // Preload the pass tally just below saturation.
    @(negedge clk);
    force dut.pass_q = 16'hFFFE;
    @(negedge clk);
    release dut.pass_q;
    mpass = 65534;
    run_txn(30, 1, 30);
    run_txn(30, 1, 31);
    run_txn(30, 1, 40);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
